// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared widths, NOP encoding and fetch state encoding
package riscv_fetch_pkg;

   localparam int XLEN    = 64;
   localparam int ILEN    = 32;
   localparam int FETCH_W = 2;

   // addi x0, x0, 0 -- shown on any queue slot that holds nothing
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_e;

   // deq_cnt encodes 0..2; the unused code 3 behaves as 2
   function automatic logic [1:0] norm_deq(input logic [1:0] req);
      return (req == 2'd3) ? 2'd2 : req;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-in/2-out circular instruction queue with flush and clamped dequeue
module fetch_queue
   import riscv_fetch_pkg::*;
#(
   parameter int QDEPTH = 8,
   parameter int PW     = $clog2(QDEPTH),
   parameter int CW     = $clog2(QDEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            enq_i,
   input  logic [ILEN-1:0] enq_instr0_i,
   input  logic [ILEN-1:0] enq_instr1_i,
   input  logic [XLEN-1:0] enq_pc0_i,
   input  logic [XLEN-1:0] enq_pc1_i,
   input  logic [1:0]      deq_cnt_i,
   output logic [CW-1:0]   count_o,
   output logic            valid0_o,
   output logic            valid1_o,
   output logic [ILEN-1:0] instr0_o,
   output logic [ILEN-1:0] instr1_o,
   output logic [XLEN-1:0] pc0_o,
   output logic [XLEN-1:0] pc1_o
);

   logic [ILEN-1:0] instr_q [QDEPTH];
   logic [XLEN-1:0] pc_q    [QDEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic [1:0]    deq_req;
   logic [1:0]    deq_n;
   logic [PW-1:0] head_p1;
   logic [PW-1:0] tail_p1;
   logic [CW-1:0] enq_amt;

   // Dequeue can never take more than is present; count is 0 or 1 whenever clamping applies
   always_comb begin
      deq_req = norm_deq(deq_cnt_i);
      deq_n   = deq_req;
      if (CW'(deq_req) > count_q) begin
         deq_n = count_q[1:0];
      end
   end

   assign head_p1 = head_q + 1'b1;
   assign tail_p1 = tail_q + 1'b1;
   assign enq_amt = enq_i ? CW'(2) : '0;

   // Pointer/count next state; pointers wrap naturally at PW bits
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(deq_n);
         tail_d  = enq_i ? (tail_q + PW'(2)) : tail_q;
         count_d = count_q + enq_amt - CW'(deq_n);
      end
   end

   // Pointer/count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; no reset needed since count gates visibility
   always_ff @(posedge clk) begin
      if (enq_i && !flush_i && !rst) begin
         instr_q[tail_q]  <= enq_instr0_i;
         pc_q[tail_q]     <= enq_pc0_i;
         instr_q[tail_p1] <= enq_instr1_i;
         pc_q[tail_p1]    <= enq_pc1_i;
      end
   end

   // Head and head+1 views, replaced by NOP/0 when the slot is empty
   always_comb begin
      valid0_o = (count_q != '0);
      valid1_o = (count_q >= CW'(2));
      instr0_o = valid0_o ? instr_q[head_q]  : NOP_INSTR;
      pc0_o    = valid0_o ? pc_q[head_q]     : '0;
      instr1_o = valid1_o ? instr_q[head_p1] : NOP_INSTR;
      pc1_o    = valid1_o ? pc_q[head_p1]    : '0;
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit_2way.sv
// rtl/fetch_unit_2way.sv - two-wide instruction fetch with redirect, stall and halt on misalignment
module fetch_unit_2way
   import riscv_fetch_pkg::*;
#(
   parameter int              QDEPTH   = 8,
   parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PC4,
   input  logic [ILEN-1:0] instr1,
   input  logic [ILEN-1:0] instr2,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   input  logic [1:0]      deq_cnt,
   output logic            out_valid0,
   output logic            out_valid1,
   output logic [ILEN-1:0] out_instr0,
   output logic [ILEN-1:0] out_instr1,
   output logic [XLEN-1:0] out_pc0,
   output logic [XLEN-1:0] out_pc1,
   output logic            misalign_err
);

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalign_q, misalign_d;

   logic            enq;
   logic            flush;
   logic [CW-1:0]   count;
   logic [CW-1:0]   free_slots;

   assign PC           = pc_q;
   assign PC4          = pc_q + XLEN'(4);
   assign misalign_err = misalign_q;

   // Space is judged on the pre-dequeue count so the enqueue never depends on decode timing
   assign free_slots = CW'(QDEPTH) - count;

   // Next-state: redirect beats stall/dequeue, HALT blocks enqueue until an aligned redirect
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = misalign_q;
      enq        = 1'b0;
      flush      = 1'b0;
      if (redirect_en) begin
         flush = 1'b1;
         if (redirect_pc[1:0] == 2'b00) begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
         end else begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            misalign_d = 1'b1;
            state_d    = ST_HALT;
         end
      end else if (state_q == ST_RUN && !stall && free_slots >= CW'(FETCH_W)) begin
         enq  = 1'b1;
         pc_d = pc_q + XLEN'(FETCH_W * 4);
      end
   end

   // State, PC and sticky error registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .enq_i        (enq),
      .enq_instr0_i (instr1),
      .enq_instr1_i (instr2),
      .enq_pc0_i    (pc_q),
      .enq_pc1_i    (PC4),
      .deq_cnt_i    (deq_cnt),
      .count_o      (count),
      .valid0_o     (out_valid0),
      .valid1_o     (out_valid1),
      .instr0_o     (out_instr0),
      .instr1_o     (out_instr1),
      .pc0_o        (out_pc0),
      .pc1_o        (out_pc1)
   );

endmodule
